// File: rtl/tinyalu_param.sv
// tinyalu_param: parametrised TinyALU with subtract, operand capture at accept,
// busy/err status and a start/done handshake that never re-triggers on a held
// start. Single-cycle ops finish one edge after accept; multiply finishes
// MUL_LAT edges after accept.
module tinyalu_param #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 err
);

    localparam int RW = 2 * WIDTH;
    // Counter only needs to hold MUL_LAT-1; keep at least one bit.
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

    localparam logic [2:0] NO_OP  = 3'b000;
    localparam logic [2:0] ADD_OP = 3'b001;
    localparam logic [2:0] AND_OP = 3'b010;
    localparam logic [2:0] XOR_OP = 3'b011;
    localparam logic [2:0] MUL_OP = 3'b100;
    localparam logic [2:0] SUB_OP = 3'b101;
    localparam logic [2:0] ILL_OP = 3'b110;
    localparam logic [2:0] RST_OP = 3'b111;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] MUL  = 2'b10;
    localparam logic [1:0] HOLD = 2'b11;

    logic [1:0]       state_reg,  state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [2:0]       op_reg,     op_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [RW-1:0]    result_reg, result_next;
    logic             err_reg,    err_next;
    logic             done_reg,   done_next;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] product;
    logic [RW-1:0] op_result;

    assign a_ext = {{WIDTH{1'b0}}, a_reg};
    assign b_ext = {{WIDTH{1'b0}}, b_reg};

    // Shift-and-add multiplier over the captured operands: each stage adds
    // the shifted A when the matching bit of B is set. The operands are
    // frozen for the whole MUL phase, so the chain settles well before use.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mul
            logic [RW-1:0] pp;
            logic [RW-1:0] acc;
            assign pp = b_reg[gi] ? (a_ext << gi) : '0;
            if (gi == 0) begin : g_first
                assign acc = pp;
            end else begin : g_rest
                assign acc = g_mul[gi-1].acc + pp;
            end
        end
    endgenerate

    assign product = g_mul[WIDTH-1].acc;

    // Result selection from the captured opcode; illegal codes yield zero.
    always_comb begin
        op_result = '0;
        case (op_reg)
            ADD_OP:  op_result = a_ext + b_ext;
            AND_OP:  op_result = a_ext & b_ext;
            XOR_OP:  op_result = a_ext ^ b_ext;
            SUB_OP:  op_result = a_ext - b_ext;
            MUL_OP:  op_result = product;
            default: op_result = '0;
        endcase
    end

    // Next-state logic for the handshake FSM and the output registers.
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        err_next    = err_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        NO_OP: begin
                            // ignored: nothing changes
                        end
                        RST_OP: begin
                            result_next = '0;
                            err_next    = 1'b0;
                        end
                        MUL_OP: begin
                            a_next     = A;
                            b_next     = B;
                            op_next    = op;
                            cnt_next   = CNT_LOAD;
                            state_next = MUL;
                        end
                        default: begin
                            a_next     = A;
                            b_next     = B;
                            op_next    = op;
                            state_next = EXEC;
                        end
                    endcase
                end
            end
            EXEC: begin
                result_next = op_result;
                err_next    = (op_reg == ILL_OP);
                done_next   = 1'b1;
                state_next  = HOLD;
            end
            MUL: begin
                if (cnt_reg == '0) begin
                    result_next = op_result;
                    err_next    = 1'b0;
                    done_next   = 1'b1;
                    state_next  = HOLD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                // Wait for the requester to drop start before re-arming.
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= NO_OP;
            cnt_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            done_reg   <= done_next;
        end
    end

    assign done   = done_reg;
    assign result = result_reg;
    assign err    = err_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: doc/tinyalu_param.md
Name: tinyalu_param

Overview:
- Parametrised next-generation TinyALU: operand width and multiply latency set by parameters.
- Adds a subtract op, operand capture at accept, busy and error outputs, and a start/done handshake protected against re-triggering.
- Sits behind the tinyalu BFM as the DUT, with the same port naming.
- Uses the 3-bit operation_t encoding: no_op 000, add_op 001, and_op 010, xor_op 011, mul_op 100, rst_op 111.
- New encodings: sub_op 101; 110 is illegal.

Parameters:
- WIDTH, 8, operand width in bits (legal range >= 2).
- MUL_LAT, 3, cycles from accept to done for mul_op (legal range >= 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- op  in  3  operation code (operation_t encoding plus sub_op 101).
- start  in  1  request; the requester holds it high until it sees done.
- done  out  1  one-cycle completion pulse.
- result  out  2*WIDTH  result of the last completed op.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  high when the last completed op was illegal.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is asynchronous and active-low: reset_n.
  - While reset_n=0: done=0, result=0, busy=0, err=0, FSM=IDLE, multiply pipeline cleared.
- FSM states:
  - IDLE, EXEC, MUL, HOLD.
- Accept:
  - A request is accepted on a rising edge where FSM=IDLE and start=1.
  - At accept, A, B and op are captured into internal registers.
  - Input changes after accept have no effect.
- Single-cycle ops (add, and, xor, sub, illegal 110):
  - IDLE -> EXEC.
  - The next edge loads result and pulses done. Latency is 1 cycle: done is high in the cycle after the accept edge.
- mul_op:
  - IDLE -> MUL; a counter is loaded with MUL_LAT-1.
  - result and done are asserted MUL_LAT cycles after the accept edge.
  - When MUL_LAT=1, the latency equals a single-cycle op.
- After done:
  - FSM -> HOLD; it stays in HOLD while start=1.
  - HOLD -> IDLE on the first edge with start=0.
  - Consequence: a start held high never re-triggers; a new op needs start low for at least one cycle.
- no_op with start in IDLE:
  - Ignored: no state change, no done.
- rst_op with start in IDLE:
  - Synchronous soft clear on that edge: result=0, err=0, FSM stays IDLE, no done.
- Arithmetic: operands are zero-extended to 2*WIDTH.
  - add: A+B; the carry lands in bit WIDTH.
  - and / xor: bitwise; the upper WIDTH bits are 0.
  - sub: (A-B) mod 2^(2*WIDTH). If A<B, the upper bits are all ones.
  - mul: full unsigned 2*WIDTH product.
- Illegal op 110:
  - Completes like a single-cycle op: done=1, err=1, result=0.
- err:
  - Updated only at done or rst_op, so it reflects the last completed op.
- result:
  - Holds its value between completions.
  - Never changes without done, except on rst_op or reset.
- busy:
  - busy=1 in EXEC, MUL and HOLD.
  - Rises the cycle after the accept edge.
- Reset asserted mid-op:
  - Immediate clear; no done is produced.
  - After release the FSM is in IDLE, so a still-high start is accepted as a fresh request.
- start while busy:
  - Ignored; no queuing.

Test Plan (WIDTH=8, MUL_LAT=3):
1. add_op, A=0xFF, B=0x01, start held -> done one cycle after accept; result=0x0100; err=0; busy high from the cycle after accept until start drops.
2. mul_op, A=0xFF, B=0xFF -> done exactly 3 cycles after accept; result=0xFE01. Changing A to 0x00 during MUL still gives 0xFE01.
3. sub_op, A=0x01, B=0x02 -> result=0xFFFF. Then and_op, A=0xF0, B=0x3C -> result=0x0030.
4. xor_op, A=0xAA, B=0x55 with start held 5 cycles past done -> exactly one done pulse, result=0x00FF. Drop start for 1 cycle and reassert -> a second done.
5. op=110 -> done with err=1, result=0x0000. Following add_op 0x02+0x03 -> err=0, result=0x0005.
6. reset_n pulled low 1 cycle into mul_op -> no done, all outputs 0. Then add_op 0x10+0x10 gives 0x0020; then rst_op with start -> result=0x0000 and no done pulse.
